// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-side partner of the fetch-stage 2-bit branch predictor. Each
// fetched instruction's prediction bit and PC metadata travel alongside it
// through internal F->D->E registers. In Execute, the prediction is compared
// with the real outcome. On a wrong path the unit redirects the predictor,
// raises a flush request for D and E, and enables training of the 2-bit
// counter. Two saturating counters record resolved conditional branches and
// resolved mispredictions.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   StallD, FlushD, FlushE     hazard-unit controls for the metadata registers
//   predict_branchF            prediction for the instruction in F
//   PCF, PCPlus4F              PC metadata of the instruction in F
//   BranchE, JumpE, JalrE      instruction type in E (B-type, JAL, JALR)
//   PCSrcE                     actual taken outcome in E
//   PCTargetE                  actual target computed in E
//   Eval_branch                B/J misprediction, selects Act_Target
//   jalr                       valid JALR in E, always redirects
//   Act_Target                 recovery PC
//   StateUpdateEnable          train the predictor with PCSrcE this cycle
//   FlushMispredict            flush request for D and E
//   branch_count               resolved conditional branches (saturating)
//   mispredict_count           resolved B/J mispredictions (saturating)
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic             predict_branchF,
    input  logic [31:0]      PCF,
    input  logic [31:0]      PCPlus4F,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             JalrE,
    input  logic             PCSrcE,
    input  logic [31:0]      PCTargetE,
    output logic             Eval_branch,
    output logic             jalr,
    output logic [31:0]      Act_Target,
    output logic             StateUpdateEnable,
    output logic             FlushMispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        validD, predD;
    logic [31:0] PCD, PCPlus4D;
    logic        validE, predE;
    logic [31:0] PCE, PCPlus4E;

    logic is_jalr, is_jal, is_branch;
    logic mispredict;

    // PCE travels with the instruction for debug visibility but no output
    // depends on it; this reduction keeps it visibly consumed.
    logic unused_pce;
    assign unused_pce = ^PCE;

    // D-stage metadata register. A redirect flush must win over a stall,
    // otherwise the wrong-path instruction held in D would survive.
    always_ff @(posedge clk) begin
        if (reset || FlushD || FlushMispredict) begin
            validD   <= 1'b0;
            predD    <= 1'b0;
            PCD      <= 32'h0;
            PCPlus4D <= 32'h0;
        end else if (!StallD) begin
            validD   <= 1'b1;
            predD    <= predict_branchF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
        end
    end

    // E-stage metadata register. Execute never stalls, so it either clears
    // or takes whatever D holds.
    always_ff @(posedge clk) begin
        if (reset || FlushE || FlushMispredict) begin
            validE   <= 1'b0;
            predE    <= 1'b0;
            PCE      <= 32'h0;
            PCPlus4E <= 32'h0;
        end else begin
            validE   <= validD;
            predE    <= predD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
        end
    end

    // Illegal combinations of type flags resolve as JALR > JAL > branch,
    // so at most one of these is ever set.
    always_comb begin
        is_jalr   = JalrE;
        is_jal    = JumpE & ~JalrE;
        is_branch = BranchE & ~JumpE & ~JalrE;
    end

    // A JAL is always taken, so it is wrong only when predicted not-taken.
    // JALR is excluded here because its target is never predicted and it
    // redirects unconditionally through the separate jalr output.
    assign mispredict        = validE & ((is_branch & (predE != PCSrcE)) |
                                         (is_jal & ~predE));
    assign Eval_branch       = mispredict;
    assign jalr              = validE & is_jalr;
    assign FlushMispredict   = Eval_branch | jalr;
    assign StateUpdateEnable = validE & is_branch;
    assign Act_Target        = (is_branch & ~PCSrcE) ? PCPlus4E : PCTargetE;

    // Statistics counters stick at all-ones instead of wrapping, so a long
    // run never reports a misleadingly small value.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (StateUpdateEnable && (branch_count != CNT_MAX))
                branch_count <= branch_count + CNT_W'(1);
            if (Eval_branch && (mispredict_count != CNT_MAX))
                mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit with a 4-bit counter width, so
// counter saturation can be reached quickly. Inputs change 1 time unit
// after each rising edge and outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallD, FlushD, FlushE;
    logic        predict_branchF;
    logic [31:0] PCF, PCPlus4F;
    logic        BranchE, JumpE, JalrE, PCSrcE;
    logic [31:0] PCTargetE;
    logic        Eval_branch, jalr, StateUpdateEnable, FlushMispredict;
    logic [31:0] Act_Target;
    logic [3:0]  branch_count, mispredict_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    branch_resolve_unit #(.CNT_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .StallD            (StallD),
        .FlushD            (FlushD),
        .FlushE            (FlushE),
        .predict_branchF   (predict_branchF),
        .PCF               (PCF),
        .PCPlus4F          (PCPlus4F),
        .BranchE           (BranchE),
        .JumpE             (JumpE),
        .JalrE             (JalrE),
        .PCSrcE            (PCSrcE),
        .PCTargetE         (PCTargetE),
        .Eval_branch       (Eval_branch),
        .jalr              (jalr),
        .Act_Target        (Act_Target),
        .StateUpdateEnable (StateUpdateEnable),
        .FlushMispredict   (FlushMispredict),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the fetch-side and execute-side inputs, then let them settle.
    task automatic applyStimulus(input logic pred, input logic [31:0] pc,
                                 input logic br, input logic jmp,
                                 input logic jr, input logic src,
                                 input logic [31:0] tgt);
        predict_branchF = pred;
        PCF             = pc;
        PCPlus4F        = pc + 32'd4;
        BranchE         = br;
        JumpE           = jmp;
        JalrE           = jr;
        PCSrcE          = src;
        PCTargetE       = tgt;
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ev,
                               input logic jr, input logic [31:0] act,
                               input logic sue, input logic fl);
        checkVal({tag, ".Eval_branch"}, {31'h0, Eval_branch}, {31'h0, ev});
        checkVal({tag, ".jalr"}, {31'h0, jalr}, {31'h0, jr});
        checkVal({tag, ".Act_Target"}, Act_Target, act);
        checkVal({tag, ".StateUpdateEnable"}, {31'h0, StateUpdateEnable}, {31'h0, sue});
        checkVal({tag, ".FlushMispredict"}, {31'h0, FlushMispredict}, {31'h0, fl});
    endtask

    task automatic checkCounts(input string tag, input logic [3:0] bc,
                               input logic [3:0] mc);
        checkVal({tag, ".branch_count"}, {28'h0, branch_count}, {28'h0, bc});
        checkVal({tag, ".mispredict_count"}, {28'h0, mispredict_count}, {28'h0, mc});
    endtask

    initial begin
        reset  = 1'b1;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state: everything idle, Act_Target follows PCTargetE.
        checkOutput("reset", 1'b0, 1'b0, 32'h55, 1'b0, 1'b0);
        checkCounts("reset", 4'd0, 4'd0);

        // First fetch 0x100 predicted taken; reaches E after two edges.
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55);
        tick();
        applyStimulus(1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55);
        tick();

        // Predicted taken, actually not taken: recover to PC+4 = 0x104.
        applyStimulus(1'b0, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h777);
        checkOutput("br_mispredict", 1'b1, 1'b0, 32'h104, 1'b1, 1'b1);
        checkCounts("br_mispredict_pre", 4'd0, 4'd0);
        tick();
        checkCounts("br_mispredict_post", 4'd1, 4'd1);
        checkOutput("br_flushed", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Correctly predicted taken branch: trains, no redirect.
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
        checkOutput("br_correct", 1'b0, 1'b0, 32'h200, 1'b1, 1'b0);
        tick();
        checkCounts("br_correct", 4'd2, 4'd1);

        // JALR (with a stray BranchE) redirects to its target, never trains.
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 32'h340);
        checkOutput("jalr", 1'b0, 1'b1, 32'h340, 1'b0, 1'b1);
        tick();
        checkCounts("jalr", 4'd2, 4'd1);
        checkOutput("jalr_bubble", 1'b0, 1'b0, 32'h340, 1'b0, 1'b0);

        // JAL predicted not-taken (with a stray BranchE) is a mispredict.
        applyStimulus(1'b0, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        applyStimulus(1'b0, 32'h400, 1'b1, 1'b1, 1'b0, 1'b1, 32'h500);
        checkOutput("jal", 1'b1, 1'b0, 32'h500, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkCounts("jal", 4'd2, 4'd2);

        // Stall D for three edges while F keeps changing.
        tick();
        StallD = 1'b1;
        applyStimulus(1'b0, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h800, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h900, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h900, 1'b1, 1'b0, 1'b0, 1'b0, 32'h999);
        checkOutput("stall_hold", 1'b1, 1'b0, 32'h604, 1'b1, 1'b1);

        // Mispredict while StallD is still high: D must clear.
        tick();
        StallD = 1'b0;
        applyStimulus(1'b1, 32'hA00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h999);
        checkCounts("stall_flush", 4'd3, 4'd3);
        checkOutput("stall_flush_e", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("stall_flush_d", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // FlushE squashes the valid instruction about to enter E.
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        #1;
        checkOutput("flushe", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkCounts("flushe", 4'd3, 4'd3);

        // Reset pulse, then a long run of mispredicting branches.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkCounts("reset2", 4'd0, 4'd0);
        for (int i = 0; i < 100; i++) begin
            if (Eval_branch === 1'b1) pulses++;
            tick();
        end
        checkVal("mispredict_pulses", {31'h0, (pulses >= 20)}, 32'h1);
        checkCounts("saturate", 4'd15, 4'd15);

        // Reset mid-operation clears counters and the E register.
        reset = 1'b1;
        tick();
        checkCounts("reset3", 4'd0, 4'd0);
        checkOutput("reset3", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
